// File: rtl/traffic_light_ctrl_if.sv
// Lamp/countdown signal bundle for traffic_light_ctrl.
// The controller side drives iEN/iPED; the sequencer side drives lamps, digit and tick.
interface traffic_light_ctrl_if;
   logic       iEN;
   logic       iPED;
   logic       oRED;
   logic       oYEL;
   logic       oGRN;
   logic [3:0] oDIG;
   logic       oTICK;

   modport master (
      output iEN,
      output iPED,
      input  oRED,
      input  oYEL,
      input  oGRN,
      input  oDIG,
      input  oTICK
   );

   modport slave (
      input  iEN,
      input  iPED,
      output oRED,
      output oYEL,
      output oGRN,
      output oDIG,
      output oTICK
   );
endinterface

// File: rtl/traffic_light_ctrl.sv
// GREEN->YELLOW->RED phase sequencer with a registered per-second BCD countdown (1..9).
// Define PED_REQ_EN to let a pedestrian request during GREEN cut the remaining GREEN time to PED_CUT.
module traffic_light_ctrl #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int GREEN_S  = 9,
   parameter int YELLOW_S = 3,
   parameter int RED_S    = 9,
   parameter int PED_CUT  = 2
) (
   input logic                 iCLK,
   input logic                 iRST,
   traffic_light_ctrl_if.slave bus
);

   localparam int unsigned     PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);
   localparam logic [3:0]      GRN_D   = 4'(GREEN_S);
   localparam logic [3:0]      YEL_D   = 4'(YELLOW_S);
   localparam logic [3:0]      RED_D   = 4'(RED_S);

   if (CLK_HZ < 2 || GREEN_S < 1 || GREEN_S > 9 || YELLOW_S < 1 || YELLOW_S > 9 ||
       RED_S < 1 || RED_S > 9) begin : g_bad_param
      $error("traffic_light_ctrl: CLK_HZ must be >= 2 and every duration in 1..9");
   end

   typedef enum logic [1:0] {
      S_RED    = 2'b00,
      S_GREEN  = 2'b01,
      S_YELLOW = 2'b10
   } state_t;

   state_t         state_d, state_q;
   logic [3:0]     dig_d, dig_q;
   logic [PW-1:0]  pre_d, pre_q;
   logic           tick;
   logic           tick_d, tick_q;
   logic           red_d, red_q;
   logic           yel_d, yel_q;
   logic           grn_d, grn_q;

`ifdef PED_REQ_EN
   localparam logic [3:0] CUT_D = 4'(PED_CUT);
   logic ped_d, ped_q;

   if (PED_CUT < 1 || PED_CUT > GREEN_S) begin : g_bad_cut
      $error("traffic_light_ctrl: PED_CUT must be in 1..GREEN_S");
   end
`else
   logic unused_ped;
   assign unused_ped = bus.iPED;

   if (PED_CUT < 1 || PED_CUT > 9) begin : g_bad_cut
      $error("traffic_light_ctrl: PED_CUT must be in 1..9");
   end
`endif

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      pre_d   = pre_q;
      tick    = 1'b0;
      tick_d  = 1'b0;
      if (bus.iEN) begin
         tick  = (pre_q == PRE_MAX);
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
      case (state_q)
         S_RED, S_GREEN, S_YELLOW: begin
            if (tick) begin
               tick_d = 1'b1;
               if (dig_q == 4'd1) begin
                  case (state_q)
                     S_GREEN: begin
                        state_d = S_YELLOW;
                        dig_d   = YEL_D;
                     end
                     S_YELLOW: begin
                        state_d = S_RED;
                        dig_d   = RED_D;
                     end
                     default: begin
                        state_d = S_GREEN;
                        dig_d   = GRN_D;
                     end
                  endcase
               end else begin
                  dig_d = dig_q - 4'd1;
`ifdef PED_REQ_EN
                  if (ped_q && dig_d > CUT_D) dig_d = CUT_D;
`endif
               end
            end
         end
         // Unused encoding: recover regardless of iEN
         default: begin
            state_d = S_RED;
            dig_d   = RED_D;
         end
      endcase
      red_d = (state_d == S_RED);
      yel_d = (state_d == S_YELLOW);
      grn_d = (state_d == S_GREEN);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= S_RED;
         dig_q   <= RED_D;
         pre_q   <= '0;
         tick_q  <= 1'b0;
         red_q   <= 1'b1;
         yel_q   <= 1'b0;
         grn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         red_q   <= red_d;
         yel_q   <= yel_d;
         grn_q   <= grn_d;
      end
   end

`ifdef PED_REQ_EN
   // Flag lives only while GREEN persists; sampling requires being in GREEN already
   always_comb begin
      ped_d = ped_q;
      if (state_d != S_GREEN) ped_d = 1'b0;
      else if (bus.iEN && state_q == S_GREEN && bus.iPED) ped_d = 1'b1;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) ped_q <= 1'b0;
      else      ped_q <= ped_d;
   end
`endif

   assign bus.oRED  = red_q;
   assign bus.oYEL  = yel_q;
   assign bus.oGRN  = grn_q;
   assign bus.oDIG  = dig_q;
   assign bus.oTICK = tick_q;

endmodule
